muldiv_unit: RTL and testbench

- Iterative multiply/divide execution unit driven by the 4-bit ALU control codes MUL, MULU, DIV and DIVU from the ALU decoder.
- Owns the architectural HI/LO registers.
- Sits beside the ALU in the EX stage; it raises busy so the hazard unit stalls the pipeline while an operation runs.
- Services MULT/MULTU/DIV/DIVU and direct HI/LO writes (MTHI/MTLO).

---
 rtl/muldiv_unit_if.sv | 33 +++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the EX stage and muldiv_unit
//
// Purpose: groups the multiply/divide request, HI/LO write port and results.
// Signals:
//   start, alu_ctr, src_a, src_b  operation request (master -> slave)
//   hi_we, lo_we, wdata           direct HI/LO write (master -> slave)
//   busy, done, div_zero, hi, lo  status and architectural HI/LO (slave -> master)
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctr;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_ctr, src_a, src_b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, alu_ctr, src_a, src_b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning HI/LO
//
// Purpose: MUL/MULU (radix-2 shift-add) and DIV/DIVU (restoring), one bit per
// cycle on magnitudes with sign correction at the end; MTHI/MTLO writes.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  muldiv_unit_if.slave: request, HI/LO write, busy/done/div_zero, hi/lo
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;       // current op is a divide
  logic               neg_q, neg_d;       // product/quotient must be negated
  logic               rneg_q, rneg_d;     // remainder must be negated
  logic [WIDTH-1:0]   b_q, b_d;           // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;   // unmodified src_a for divide-by-zero
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi part, lo part} working register
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               valid_op, sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod_fix;

  // 4'b10xx are the four multiply/divide codes; bit1 selects divide, bit0 unsigned
  assign valid_op = (bus.alu_ctr[3:2] == 2'b10);
  assign sgn      = ~bus.alu_ctr[0];
  assign a_neg    = sgn & bus.src_a[WIDTH-1];
  assign b_neg    = sgn & bus.src_b[WIDTH-1];
  assign a_mag    = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag    = b_neg ? -bus.src_b : bus.src_b;

  // Multiply step: conditionally add the multiplicand to the upper half, then
  // shift the whole accumulator right (carry lands in the top bit).
  assign addend   = acc_q[0] ? b_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // Divide step: remainder shifted left with the next dividend bit, minus divisor.
  assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};

  assign prod_fix = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    b_d     = b_q;
    raw_a_d = raw_a_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (valid_op) begin
            div_d   = bus.alu_ctr[1];
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            b_d     = b_mag;
            raw_a_d = bus.src_a;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            cnt_d   = CW'(WIDTH);
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end

      CALC: begin
        if (div_q) begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end

      FIX: begin
        if (div_q) begin
          if (b_q == '0) begin
            // Divide by zero: raw dividend in HI, no sign correction
            lo_d = '1;
            hi_d = raw_a_q;
            dz_d = 1'b1;
          end else begin
            lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      b_q     <= '0;
      raw_a_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      b_q     <= b_d;
      raw_a_q <= raw_a_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 32;

  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;

  typedef struct {
    string      name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  muldiv_unit_if #(.WIDTH(W)) mif ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mif.done) begin
      check("done_busy_exclusive", 64'(mif.busy), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_hi"}, 64'(mif.hi), 64'(e.hi));
        check({e.name, "_lo"}, 64'(mif.lo), 64'(e.lo));
        check({e.name, "_dz"}, 64'(mif.div_zero), 64'(e.dz));
      end
    end
  end

  task automatic drive_start(input logic [3:0] ctr, input logic [W-1:0] a, input logic [W-1:0] b);
    mif.start   = 1'b1;
    mif.alu_ctr = ctr;
    mif.src_a   = a;
    mif.src_b   = b;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cycles = 0;
    while (mif.busy && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({name, "_busy_cycles"}, 64'(cycles), 64'd33);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [3:0] ctr, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edz);
    exp_t e;
    e.name = name; e.hi = ehi; e.lo = elo; e.dz = edz;
    exp_q.push_back(e);
    drive_start(ctr, a, b);
    wait_idle(name);
  endtask

  initial begin
    int waited;
    exp_t e;
    mif.start = 1'b0; mif.alu_ctr = 4'b0000; mif.src_a = '0; mif.src_b = '0;
    mif.hi_we = 1'b0; mif.lo_we = 1'b0; mif.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 64'(mif.busy), 64'd0);
    check("reset_done", 64'(mif.done), 64'd0);
    check("reset_dz",   64'(mif.div_zero), 64'd0);
    check("reset_hi",   64'(mif.hi), 64'd0);
    check("reset_lo",   64'(mif.lo), 64'd0);

    run_op("mul_neg3x5",   OP_MUL,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("mulu_max",     OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mul_m1xm1",    OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    run_op("div_m7_2",     OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_7_m2",     OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("divu_100_7",   OP_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
    run_op("div_overflow", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_by0",     OP_DIVU, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1);
    check("dz_sticky", 64'(mif.div_zero), 64'd1);
    run_op("div_neg_by0",  OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_op("divu_10_3",    OP_DIVU, 32'd10,       32'd3,        32'h00000001, 32'h00000003, 1'b0);

    // Reset mid-operation: nothing may reach HI/LO and no done may follow
    drive_start(OP_MUL, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 64'(mif.busy), 64'd0);
    check("abort_hi",   64'(mif.hi), 64'd0);
    check("abort_lo",   64'(mif.lo), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    run_op("mul_6x7", OP_MUL, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // Idle MTHI
    mif.hi_we = 1'b1; mif.wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1;
    mif.hi_we = 1'b0;
    check("mthi_idle", 64'(mif.hi), 64'hCAFEBABE);
    check("mthi_lo_kept", 64'(mif.lo), 64'd42);

    // Writes and a second start while busy are ignored
    e.name = "mulu_2x3"; e.hi = 32'd0; e.lo = 32'd6; e.dz = 1'b0;
    exp_q.push_back(e);
    drive_start(OP_MULU, 32'd2, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    mif.hi_we = 1'b1; mif.lo_we = 1'b1; mif.wdata = 32'h12345678;
    mif.start = 1'b1; mif.alu_ctr = OP_MULU; mif.src_a = 32'd100; mif.src_b = 32'd100;
    @(posedge clk);
    #1;
    mif.hi_we = 1'b0; mif.lo_we = 1'b0; mif.start = 1'b0;
    check("busy_write_hi", 64'(mif.hi), 64'hCAFEBABE);
    check("busy_write_lo", 64'(mif.lo), 64'd42);
    waited = 0;
    while (mif.busy && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("busy_start_ignored_len", 64'(waited), 64'd29);
    @(posedge clk);
    #1;

    // start and lo_we together: start wins, write dropped
    e.name = "mulu_3x3"; e.hi = 32'd0; e.lo = 32'd9; e.dz = 1'b0;
    exp_q.push_back(e);
    mif.lo_we = 1'b1; mif.wdata = 32'hDEADBEEF;
    drive_start(OP_MULU, 32'd3, 32'd3);
    mif.lo_we = 1'b0;
    check("start_wins_busy", 64'(mif.busy), 64'd1);
    check("start_wins_lo",   64'(mif.lo), 64'd6);
    wait_idle("mulu_3x3");

    // Invalid code is ignored
    drive_start(4'b0010, 32'd5, 32'd5);
    check("bad_code_busy", 64'(mif.busy), 64'd0);
    check("bad_code_lo",   64'(mif.lo), 64'd9);

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
